// File: rtl/serial_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_disp_pkg
// Purpose  : Shared types and constants for the serial display receiver:
//            FSM state encoding, active-low 7-segment code table, and the
//            default frame length.
// Revision : 1.0 - initial release
// ============================================================================
package serial_disp_pkg;

    // Default number of bits in one display frame
    localparam int DEFAULT_FRAME_BITS = 64;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } disp_state_e;

    // Active-low segment codes (bits 6:0), entry n is the pattern for hex digit n
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Maps one active-low 7-segment pattern back to its hex nibble.
//            Patterns not in the table decode to 0 with o_ok low.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import serial_disp_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_ok
);

    // Table search; codes are unique so at most one entry matches
    always_comb begin
        o_nibble = 4'd0;
        o_ok     = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (i_seg == SEG_CODES[n]) begin
                o_nibble = 4'(n);
                o_ok     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_disp_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_disp_rx
// Purpose  : Receives serially shifted display frames (ser_clk/ser_dat, framed
//            by ser_pen, cleared by ser_clrn), validates the bit count and
//            publishes good frames on frame_data.
//            Optional macro SERIAL_DISP_RX_SEG_DECODE_EN adds registered
//            7-segment-to-hex decoding of all 8 frame bytes.
// Revision : 1.0 - initial release
// ============================================================================
module serial_disp_rx
    import serial_disp_pkg::*;
#(
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_cpu,
    input  logic        rst_cpu,
    input  logic        ser_clk,
    input  logic        ser_dat,
    input  logic        ser_pen,
    input  logic        ser_clrn,
    output logic [63:0] frame_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [6:0]  bit_cnt
`ifdef SERIAL_DISP_RX_SEG_DECODE_EN
    ,
    output logic [31:0] digits,
    output logic [7:0]  digit_ok
`endif
);

    localparam logic [6:0]  CNT_FULL   = 7'(FRAME_BITS);
    localparam logic [6:0]  CNT_SAT    = 7'(FRAME_BITS + 1);
    localparam logic [63:0] FRAME_MASK = (FRAME_BITS >= 64) ? {64{1'b1}}
                                       : ((64'd1 << FRAME_BITS) - 64'd1);

    // Synchronizer vector layout: {clrn, pen, dat, clk}
    logic [3:0]  sync_d [SYNC_STAGES];
    logic [3:0]  sync_q [SYNC_STAGES];
    logic [1:0]  edge_d, edge_q;          // delayed {pen, clk} for edge detect
    logic [3:0]  w_last;
    logic        w_clk_rise, w_pen_rise, w_dat, w_pen, w_clr;

    disp_state_e state_d, state_q;
    logic [6:0]  cnt_d, cnt_q;
    logic [63:0] shreg_d, shreg_q;
    logic [63:0] frame_d, frame_q;
    logic        valid_d, valid_q;
    logic        err_d, err_q;

    // Synchronizer chain plus one extra stage for edge detection
    always_comb begin
        sync_d[0] = {ser_clrn, ser_pen, ser_dat, ser_clk};
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        edge_d = {sync_q[SYNC_STAGES-1][2], sync_q[SYNC_STAGES-1][0]};
    end

    // Synchronizer flops idle at bus level (all ones) out of reset
    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= 4'hF;
            end
            edge_q <= 2'b11;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            edge_q <= edge_d;
        end
    end

    assign w_last     = sync_q[SYNC_STAGES-1];
    assign w_clk_rise = w_last[0] & ~edge_q[0];
    assign w_pen_rise = w_last[2] & ~edge_q[1];
    assign w_dat      = w_last[1];
    assign w_pen      = w_last[2];
    assign w_clr      = ~w_last[3];

    // Frame FSM: clear overrides, a bit shifted in the commit-detect cycle still counts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        frame_d = frame_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (w_clr) begin
            state_d = IDLE;
            cnt_d   = 7'd0;
            shreg_d = 64'd0;
            frame_d = 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!w_pen) begin
                        state_d = SHIFT;
                        cnt_d   = 7'd0;
                        shreg_d = 64'd0;
                    end
                end
                SHIFT: begin
                    if (w_clk_rise) begin
                        shreg_d = {shreg_q[62:0], w_dat};
                        if (cnt_q != CNT_SAT) begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                    if (w_pen_rise) begin
                        state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    state_d = IDLE;
                    if (cnt_q == CNT_FULL) begin
                        frame_d = shreg_q & FRAME_MASK;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame state registers
    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            shreg_q <= 64'd0;
            frame_q <= 64'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign frame_data  = frame_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign bit_cnt     = cnt_q;

`ifdef SERIAL_DISP_RX_SEG_DECODE_EN
    logic [31:0] digits_d, digits_q;
    logic [7:0]  dok_d, dok_q;

    // One decoder per frame byte; the dp bit (bit 7) is not decoded
    generate
        for (genvar i = 0; i < 8; i++) begin : g_seg
            seg7_decode u_dec (
                .i_seg    (frame_q[8*i +: 7]),
                .o_nibble (digits_d[4*i +: 4]),
                .o_ok     (dok_d[i])
            );
        end
    endgenerate

    // Decoded digits lag frame_data by one cycle
    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            digits_q <= 32'd0;
            dok_q    <= 8'd0;
        end else begin
            digits_q <= digits_d;
            dok_q    <= dok_d;
        end
    end

    assign digits   = digits_q;
    assign digit_ok = dok_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_disp_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_disp_rx
// Purpose  : Scoreboard bench for serial_disp_rx. Stimulus pushes expected
//            commit results; a monitor pops and compares on each pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_disp_rx;

    localparam int FB = 64;
    localparam int SS = 2;

    logic        clk_cpu  = 1'b0;
    logic        rst_cpu  = 1'b1;
    logic        ser_clk  = 1'b1;
    logic        ser_dat  = 1'b1;
    logic        ser_pen  = 1'b1;
    logic        ser_clrn = 1'b1;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [6:0]  bit_cnt;
`ifdef SERIAL_DISP_RX_SEG_DECODE_EN
    logic [31:0] digits;
    logic [7:0]  digit_ok;
`endif

    serial_disp_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .clk_cpu     (clk_cpu),
        .rst_cpu     (rst_cpu),
        .ser_clk     (ser_clk),
        .ser_dat     (ser_dat),
        .ser_pen     (ser_pen),
        .ser_clrn    (ser_clrn),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .bit_cnt     (bit_cnt)
`ifdef SERIAL_DISP_RX_SEG_DECODE_EN
        ,
        .digits      (digits),
        .digit_ok    (digit_ok)
`endif
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
        logic [31:0] dig;
        logic [7:0]  ok;
        int          pen_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [63:0] last_good = 64'd0;

    localparam logic [63:0] F1 = 64'hC0F9A4B0_99928280;
    localparam logic [63:0] F2 = 64'hC0F9A4B0_99FF8280;
    localparam logic [63:0] F3 = 64'h12345678_9ABCDEF0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk_cpu) cyc <= cyc + 1;

    // Monitor: compare each output pulse with the head of the scoreboard
    bit          pend = 1'b0;
    logic [31:0] pdig;
    logic [7:0]  pok;
    always @(negedge clk_cpu) begin
        exp_t e;
        if (rst_cpu) begin
            pend = 1'b0;
        end else begin
`ifdef SERIAL_DISP_RX_SEG_DECODE_EN
            if (pend) begin
                chk("digits", 64'(digits), 64'(pdig));
                chk("digit_ok", 64'(digit_ok), 64'(pok));
            end
`endif
            pend = 1'b0;
            if (frame_valid || frame_err) begin
                chk("pulse_exclusive", 64'(frame_valid & frame_err), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 64'({frame_valid, frame_err}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", 64'({frame_valid, frame_err}),
                        e.is_err ? 64'd1 : 64'd2);
                    chk("frame_data", frame_data, e.data);
                    chk("latency", 64'(cyc - e.pen_cyc), 64'(SS + 2));
                    if (!e.is_err) begin
                        pend = 1'b1;
                        pdig = e.dig;
                        pok  = e.ok;
                    end
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk_cpu);
    endtask

    task automatic send_bit(logic b);
        ser_clk = 1'b0;
        ser_dat = b;
        tick(4);
        ser_clk = 1'b1;
        tick(4);
    endtask

    task automatic shift_bits(logic [63:0] d, int n);
        ser_pen = 1'b0;
        tick(4);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit((i < 64) ? d[i[5:0]] : 1'b0);
        end
        tick(2);
    endtask

    task automatic commit(bit is_err, logic [63:0] data, logic [31:0] dig, logic [7:0] ok);
        exp_t e;
        e.is_err  = is_err;
        e.data    = data;
        e.dig     = dig;
        e.ok      = ok;
        e.pen_cyc = cyc;
        sb.push_back(e);
        ser_pen = 1'b1;
        tick(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        chk("rst_frame_data", frame_data, 64'd0);
        chk("rst_valid", 64'(frame_valid), 64'd0);
        chk("rst_err", 64'(frame_err), 64'd0);
        chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        rst_cpu = 1'b0;
        tick(4);

        // Good 64-bit frame
        shift_bits(F1, 64);
        chk("bit_cnt_64", 64'(bit_cnt), 64'd64);
        commit(1'b0, F1, 32'h01234568, 8'hFF);
        last_good = F1;

        // Short frame: rejected, data held
        shift_bits(64'h0123456789ABCDEF, 63);
        chk("bit_cnt_63", 64'(bit_cnt), 64'd63);
        commit(1'b1, last_good, 32'd0, 8'd0);

        // Long frame: count saturates, rejected
        shift_bits(F1, 70);
        chk("bit_cnt_sat", 64'(bit_cnt), 64'd65);
        commit(1'b1, last_good, 32'd0, 8'd0);

        // Unmatched segment byte at position 2
        shift_bits(F2, 64);
        commit(1'b0, F2, 32'h01234068, 8'hFB);
        last_good = F2;

        // Display clear: data wiped, no pulse
        ser_clrn = 1'b0;
        tick(4);
        ser_clrn = 1'b1;
        tick(6);
        chk("clr_frame_data", frame_data, 64'd0);
        chk("clr_bit_cnt", 64'(bit_cnt), 64'd0);
`ifdef SERIAL_DISP_RX_SEG_DECODE_EN
        chk("clr_digits", 64'(digits), 64'h88888888);
        chk("clr_digit_ok", 64'(digit_ok), 64'hFF);
`endif

        // Reset in the middle of a frame, then a full new frame
        ser_pen = 1'b0;
        tick(4);
        for (int i = 0; i < 30; i++) send_bit(i[0]);
        rst_cpu = 1'b1;
        ser_pen = 1'b1;
        ser_clk = 1'b0;
        tick(1);
        chk("midrst_bit_cnt", 64'(bit_cnt), 64'd0);
        chk("midrst_frame_data", frame_data, 64'd0);
        tick(2);
        rst_cpu = 1'b0;
        tick(4);
        shift_bits(F3, 64);
        chk("bit_cnt_after_rst", 64'(bit_cnt), 64'd64);
        commit(1'b0, F3, 32'h50070000, 8'h90);

        tick(10);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_disp_rx.md
SERIAL_DISP_RX -- requirements
Module: serial_disp_rx

Interface
REQ-001 Parameter FRAME_BITS, default 64, SHALL be the number of bits in one valid display frame (8..64).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the synchronizer depth on every ser_* input (2..3).
REQ-003 clk_cpu  input  1  SHALL be the system clock; all state changes on its rising edge.
REQ-004 rst_cpu  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 ser_clk  input  1  SHALL be the serial shift clock; data is sampled on its rising edge.
REQ-006 ser_dat  input  1  SHALL be the serial data, MSB of the frame first.
REQ-007 ser_pen  input  1  SHALL be the refresh enable: low = shift window, rising edge = commit.
REQ-008 ser_clrn  input  1  SHALL be the active-low display clear.
REQ-009 frame_data  output  64  SHALL hold the last committed frame, right-aligned in bits [FRAME_BITS-1:0].
REQ-010 frame_valid  output  1  SHALL be a one-cycle pulse on each good commit.
REQ-011 frame_err  output  1  SHALL be a one-cycle pulse on each rejected commit.
REQ-012 bit_cnt  output  7  SHALL be the bits received in the current window, saturating at FRAME_BITS+1.

Function
REQ-013 All ser_* inputs SHALL pass through SYNC_STAGES flops, then edge detection on the last two stages.
REQ-014 ser_clk high and low phases SHALL each be at least SYNC_STAGES+1 clk_cpu periods; shorter phases are not guaranteed to be sampled.
REQ-015 The FSM SHALL have states IDLE, SHIFT and COMMIT.
REQ-016 IDLE -> SHIFT when synchronized ser_pen is low; on entry, bit_cnt and the shift register clear to 0.
REQ-017 In SHIFT, each detected ser_clk rise SHALL shift ser_dat into shift-register bit 0 and increment bit_cnt, saturating at FRAME_BITS+1.
REQ-018 ser_clk edges outside SHIFT SHALL be ignored.
REQ-019 SHIFT -> COMMIT on a detected ser_pen rise; COMMIT -> IDLE unconditionally after one cycle.
REQ-020 In COMMIT with bit_cnt == FRAME_BITS: frame_data <= shift register and frame_valid = 1; otherwise frame_data is unchanged and frame_err = 1.
REQ-021 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-022 Latency: frame_valid/frame_err SHALL assert exactly SYNC_STAGES+2 clk_cpu cycles after ser_pen rises at the pin.
REQ-023 A ser_clk rise and a ser_pen rise detected in the same cycle: the bit SHALL be shifted and counted before the commit check.
REQ-024 Synchronized ser_clrn low SHALL override everything: frame_data, shift register and bit_cnt go to 0, FSM goes to IDLE, no pulses are generated.

Reset
REQ-025 rst_cpu high SHALL immediately set FSM = IDLE, frame_data = 0, frame_valid = 0, frame_err = 0, bit_cnt = 0, and all synchronizer flops = 1 (idle bus level).
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release starts at the next ser_pen low.

Configuration
REQ-027 With SERIAL_DISP_RX_SEG_DECODE_EN defined, outputs digits[31:0] and digit_ok[7:0] SHALL exist: byte i of frame_data (bits 8i+7..8i) is decoded to hex nibble i, using bits [6:0] only and ignoring dp bit 7.
REQ-028 Active-low segment codes (bits 6:0): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E; an unmatched byte SHALL give nibble 0 with digit_ok[i] = 0.
REQ-029 digits and digit_ok SHALL be registered, updating one cycle after frame_data changes.
REQ-030 Without the macro, these ports and the decode logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package serial_disp_pkg SHALL hold the FSM state enum, the 16-entry segment-code constant table and the default FRAME_BITS.
REQ-032 Sub-module seg7_decode (one byte -> nibble + ok) SHALL be instantiated 8 times, only under the macro.

Verification
REQ-033 Shift 64 bits of 64'hC0F9A4B0_99928280, then raise ser_pen -> frame_valid pulse; frame_data = 64'hC0F9A4B0_99928280; with macro, digits = 32'h01234568 and digit_ok = 8'hFF.
REQ-034 Shift 63 bits, then raise ser_pen -> frame_err pulse; frame_data keeps its previous value; bit_cnt = 63 before COMMIT.
REQ-035 Shift 70 bits -> bit_cnt saturates at 65; frame_err pulse on commit.
REQ-036 Drive ser_clrn low for 4 cycles after a good frame -> frame_data = 0; no frame_valid pulse.
REQ-037 Assert rst_cpu after 30 bits, release, then send a full 64-bit frame -> exactly one frame_valid pulse, carrying the new data.
REQ-038 With macro, byte 8'hFF at i=2 -> digit_ok = 8'hFB and digits[11:8] = 0.
